word_framer: RTL
================

# word_framer

Transmit-side framer for the 32-bit word link. After reset or each PHY initialisation it emits a preamble of sync words (32'hF731_8CEF), then forwards buffered payload words to the PHY serialiser whenever the serialiser requests data. It sits between the payload source and the PHY serialiser. It is the counterpart of the receive-side word aligner, which searches the bit stream for the same sync word at any of 32 bit offsets.

## Interface
Parameters:
- SYNC_COUNT, default 2: number of consecutive sync words in the preamble. Minimum 2, so that one complete sync word lies inside the receiver's 63-bit window at any bit offset.
- FIFO_DEPTH, default 8: payload buffer depth in words. Must be a power of 2, minimum 2.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RSTX  in  1  asynchronous, active-low reset.
- PHY_INIT  in  1  PHY (re)initialisation; synchronous, level-sensitive.
- TX_EN  in  1  serialiser ready; one output word may be produced per cycle while high.
- DIPUSH  in  1  payload word valid.
- DIN  in  32  payload word.
- FULL  out  1  payload buffer full; registered.
- DOPUSH  out  1  DOUT valid; registered.
- DOUT  out  32  output word; registered.
- SYNC_DONE  out  1  preamble complete; payload now forwarded.
- OVERFLOW  out  1  sticky flag: a push was dropped.

## Operation
- FSM states: INIT, SYNC, DATA.
  - Reset state is SYNC, with the sync counter at 0.
- PHY_INIT=1 (highest priority, from any state):
  - go to INIT;
  - flush the FIFO (count, read and write pointers to 0);
  - clear the sync counter and OVERFLOW;
  - DOPUSH=0 next cycle.
  - DIPUSH is ignored.
- INIT: when PHY_INIT=0, go to SYNC.
- SYNC: each cycle with TX_EN=1:
  - DOPUSH=1, DOUT=32'hF731_8CEF, counter increments;
  - on the SYNC_COUNT-th word, go to DATA.
  - Payload pushes are accepted into the FIFO during SYNC.
- DATA: each cycle with TX_EN=1 and FIFO not empty:
  - pop the head word; DOPUSH=1, DOUT=head word.
  - Otherwise DOPUSH=0, and DOUT holds its last value.
- No idle fill: gaps are expressed by DOPUSH=0. The receiver shifts only on push, so gaps are harmless.
- Payload push:
  - accepted when DIPUSH=1 and FULL=0;
  - DIPUSH=1 with FULL=1 drops the word and sets OVERFLOW.
  - FULL is a registered view of count==FIFO_DEPTH. A simultaneous pop does not rescue a push made while FULL=1.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both take effect.
  - Push into an empty FIFO is not bypassed: the word is poppable the next cycle at the earliest.
- SYNC_DONE = (state==DATA); registered with the state.
- Payload that happens to equal the sync pattern is not escaped. The source must avoid sync-like data during the preamble window; this is a documented limitation.
- Count width: $clog2(FIFO_DEPTH)+1. Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.

## Timing
- Reset values: DOPUSH=0, DOUT=0, FULL=0, SYNC_DONE=0, OVERFLOW=0. Reset state is SYNC with the counter at 0.
- Latency: TX_EN sampled at cycle n gives DOPUSH/DOUT at n+1.
- DIN pushed at n:
  - visible at the FIFO head at n+1;
  - earliest DOUT at n+2.
- After PHY_INIT falls at cycle n (last high cycle n-1):
  - first sync word on DOUT at n+2 at the earliest, given TX_EN=1 at n+1;
  - SYNC_DONE rises together with the last sync word's DOPUSH.
- FULL updates the cycle after the count reaches or leaves DEPTH.
- PHY_INIT asserted mid-preamble or mid-data: DOPUSH=0 from the next cycle, and the FIFO contents are lost.

## Structure
- Shared package word_link_pkg holds SYNC_WORD = 32'hF731_8CEF, used by both this block and the aligner, and the FSM state encoding.
- Sub-module word_fifo contains the synchronous FIFO: push, pop, data, count and full/empty. The framer holds the FSM, sync counter, output registers and OVERFLOW.

## Test plan
- Reset, PHY_INIT low, TX_EN=1 constant -> exactly 2 DOPUSH words of F7318CEF, then SYNC_DONE=1 and DOPUSH=0 while the FIFO is empty.
- Push 1,2,3 during the preamble, TX_EN=1 -> DOUT sequence F7318CEF, F7318CEF, 1, 2, 3 on consecutive cycles.
- TX_EN toggling 1,0,1,0 in DATA with 4 words buffered -> one word per TX_EN=1 cycle, order preserved, no duplicates.
- Push 9 words with TX_EN=0, DEPTH 8 -> FULL=1 after the 8th, 9th dropped, OVERFLOW=1. Then TX_EN=1 -> words 1..8 out, FULL falls.
- PHY_INIT pulse in DATA with 3 words buffered -> DOPUSH=0 next cycle, FIFO emptied, OVERFLOW cleared, then the preamble restarts.
- Loopback into the word aligner with the stream rotated by 0, 13 and 31 bits -> ALIGNED=1 and payload recovered intact.

Source files
------------

// File: rtl/word_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : word_link_pkg
// Description : Shared sync word and framer state encoding for the word link.
// Revision    : 1.0 - initial release
// ============================================================================
package word_link_pkg;

    localparam int          WORD_W    = 32;
    localparam logic [31:0] SYNC_WORD = 32'hF731_8CEF;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/word_fifo.sv
`default_nettype none
// ============================================================================
// Module      : word_fifo
// Description : Synchronous payload FIFO with flush and registered full flag.
// Revision    : 1.0 - initial release
// ============================================================================
module word_fifo
    import word_link_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic [WORD_W-1:0] i_din,
    input  logic              i_pop,
    output logic [WORD_W-1:0] o_head,
    output logic              o_empty,
    output logic              o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;
    logic              full_q,   full_d;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_empty   = (count_q == '0);
    assign w_do_push = i_push && !full_q && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;
    assign o_head    = mem_q[rd_ptr_q];
    assign o_full    = full_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (w_do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        // Registered from the next count so FULL always mirrors count==DEPTH.
        full_d = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q] <= i_din;
    end

endmodule
`default_nettype wire

// File: rtl/word_framer.sv
`default_nettype none
// ============================================================================
// Module      : word_framer
// Description : Transmit framer: sync-word preamble, then buffered payload.
// Revision    : 1.0 - initial release
// ============================================================================
module word_framer
    import word_link_pkg::*;
#(
    parameter int SYNC_COUNT = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        RSTX,
    input  logic        PHY_INIT,
    input  logic        TX_EN,
    input  logic        DIPUSH,
    input  logic [31:0] DIN,
    output logic        FULL,
    output logic        DOPUSH,
    output logic [31:0] DOUT,
    output logic        SYNC_DONE,
    output logic        OVERFLOW
);

    localparam int SCW = $clog2(SYNC_COUNT + 1);

    state_t            state_q,     state_d;
    logic [SCW-1:0]    cnt_q,       cnt_d;
    logic              dopush_q,    dopush_d;
    logic [WORD_W-1:0] dout_q,      dout_d;
    logic              sync_done_q, sync_done_d;
    logic              overflow_q,  overflow_d;

    logic              w_pop;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic [WORD_W-1:0] w_fifo_head;

    word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RSTX),
        .i_flush (PHY_INIT),
        .i_push  (DIPUSH),
        .i_din   (DIN),
        .i_pop   (w_pop),
        .o_head  (w_fifo_head),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dopush_d   = 1'b0;
        dout_d     = dout_q;
        overflow_d = overflow_q;
        w_pop      = 1'b0;
        if (PHY_INIT) begin
            state_d    = ST_INIT;
            cnt_d      = '0;
            overflow_d = 1'b0;
        end else begin
            // The drop decision uses the registered FULL, so a same-cycle pop cannot rescue it.
            if (DIPUSH && w_fifo_full) overflow_d = 1'b1;
            case (state_q)
                ST_INIT: state_d = ST_SYNC;
                ST_SYNC: begin
                    if (TX_EN) begin
                        dopush_d = 1'b1;
                        dout_d   = SYNC_WORD;
                        cnt_d    = cnt_q + SCW'(1);
                        if (cnt_q == SCW'(SYNC_COUNT - 1)) state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (TX_EN && !w_fifo_empty) begin
                        w_pop    = 1'b1;
                        dopush_d = 1'b1;
                        dout_d   = w_fifo_head;
                    end
                end
                default: state_d = ST_SYNC;
            endcase
        end
        sync_done_d = (state_d == ST_DATA);
    end

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            state_q     <= ST_SYNC;
            cnt_q       <= '0;
            dopush_q    <= 1'b0;
            dout_q      <= '0;
            sync_done_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dopush_q    <= dopush_d;
            dout_q      <= dout_d;
            sync_done_q <= sync_done_d;
            overflow_q  <= overflow_d;
        end
    end

    assign FULL      = w_fifo_full;
    assign DOPUSH    = dopush_q;
    assign DOUT      = dout_q;
    assign SYNC_DONE = sync_done_q;
    assign OVERFLOW  = overflow_q;

endmodule
`default_nettype wire
